// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates the icache and dcache memory channels onto one
// shared RAM port. Dcache has priority, but icache is guaranteed a grant after
// D_STREAK_MAX back-to-back dcache completions while it is waiting. RAM
// strobes, address and store data are registered at the grant edge and held
// stable for the whole transaction; ERROR cycles are counted and retried.
module mem_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int D_STREAK_MAX = 4,
   parameter int ERR_CNT_W    = 8
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 iREN,
   input  logic [ADDR_W-1:0]    iaddr,
   output logic                 iwait,
   output logic [DATA_W-1:0]    iload,
   input  logic                 dREN,
   input  logic                 dWEN,
   input  logic [ADDR_W-1:0]    daddr,
   input  logic [DATA_W-1:0]    dstore,
   output logic                 dwait,
   output logic [DATA_W-1:0]    dload,
   output logic                 ramREN,
   output logic                 ramWEN,
   output logic [ADDR_W-1:0]    ramaddr,
   output logic [DATA_W-1:0]    ramstore,
   input  logic [DATA_W-1:0]    ramload,
   input  logic [1:0]           ramstate,
   output logic [ERR_CNT_W-1:0] err_cnt
);

   localparam int SW = $clog2(D_STREAK_MAX + 1);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SERV_I = 2'd1;
   localparam logic [1:0] SERV_D = 2'd2;

   localparam logic [1:0] RS_ACCESS = 2'd2;
   localparam logic [1:0] RS_ERROR  = 2'd3;

   logic [1:0]    state;
   logic [SW-1:0] dstreak;
   logic          dreq;
   logic          idone;
   logic          ddone;
   logic          dgrant;

   // Completion detection, grant decision and pass-through read data.
   // A completion is suppressed while RST is high so a reset never emits a
   // wait-low pulse for the transaction it abandons.
   always_comb begin
      dreq   = dREN | dWEN;
      idone  = (state == SERV_I) && iREN && (ramstate == RS_ACCESS) && !RST;
      ddone  = (state == SERV_D) && dreq && (ramstate == RS_ACCESS) && !RST;
      dgrant = dreq && !(iREN && (dstreak == SW'(D_STREAK_MAX)));
      iwait  = !idone;
      dwait  = !ddone;
      iload  = ramload;
      dload  = ramload;
   end

   // Grant FSM and registered RAM strobes/address/store data.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= IDLE;
         ramREN   <= 1'b0;
         ramWEN   <= 1'b0;
         ramaddr  <= '0;
         ramstore <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (dgrant) begin
                  state    <= SERV_D;
                  ramREN   <= !dWEN;
                  ramWEN   <= dWEN;
                  ramaddr  <= daddr;
                  ramstore <= dstore;
               end else if (iREN) begin
                  state   <= SERV_I;
                  ramREN  <= 1'b1;
                  ramWEN  <= 1'b0;
                  ramaddr <= iaddr;
               end
            end
            SERV_I: begin
               if (!iREN || ramstate == RS_ACCESS) begin
                  state  <= IDLE;
                  ramREN <= 1'b0;
                  ramWEN <= 1'b0;
               end
            end
            SERV_D: begin
               if (!dreq || ramstate == RS_ACCESS) begin
                  state  <= IDLE;
                  ramREN <= 1'b0;
                  ramWEN <= 1'b0;
               end
            end
            default: begin
               state  <= IDLE;
               ramREN <= 1'b0;
               ramWEN <= 1'b0;
            end
         endcase
      end
   end

   // Dcache streak counter bounding how long a waiting icache can starve.
   always_ff @(posedge CLK) begin
      if (RST) begin
         dstreak <= '0;
      end else if (idone) begin
         dstreak <= '0;
      end else if (state == IDLE && !iREN) begin
         dstreak <= '0;
      end else if (ddone && iREN && dstreak != SW'(D_STREAK_MAX)) begin
         dstreak <= dstreak + 1'b1;
      end
   end

   // Saturating count of RAM ERROR cycles observed while serving.
   always_ff @(posedge CLK) begin
      if (RST) begin
         err_cnt <= '0;
      end else if (state != IDLE && ramstate == RS_ERROR && err_cnt != '1) begin
         err_cnt <= err_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios followed by random traffic, all checked
// cycle by cycle against a transaction-level reference model of the arbiter.
module tb_mem_arbiter;

   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int SMAX = 4;
   localparam int EW   = 8;

   localparam logic [1:0] FREE   = 2'd0;
   localparam logic [1:0] BUSY   = 2'd1;
   localparam logic [1:0] ACCESS = 2'd2;
   localparam logic [1:0] ERROR  = 2'd3;

   logic          CLK = 1'b0;
   logic          RST;
   logic          iREN;
   logic [AW-1:0] iaddr;
   logic          iwait;
   logic [DW-1:0] iload;
   logic          dREN;
   logic          dWEN;
   logic [AW-1:0] daddr;
   logic [DW-1:0] dstore;
   logic          dwait;
   logic [DW-1:0] dload;
   logic          ramREN;
   logic          ramWEN;
   logic [AW-1:0] ramaddr;
   logic [DW-1:0] ramstore;
   logic [DW-1:0] ramload;
   logic [1:0]    ramstate;
   logic [EW-1:0] err_cnt;

   always #5 CLK = ~CLK;

   mem_arbiter #(
      .ADDR_W(AW),
      .DATA_W(DW),
      .D_STREAK_MAX(SMAX),
      .ERR_CNT_W(EW)
   ) dut (
      .CLK(CLK), .RST(RST),
      .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .dwait(dwait), .dload(dload),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
      .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
      .err_cnt(err_cnt)
   );

   int errors = 0;
   int checks = 0;

   // Reference model: who is being served (0 none, 1 icache, 2 dcache) and
   // the transaction taken at grant time.
   int          serving  = 0;
   logic [31:0] m_addr   = '0;
   logic [31:0] m_store  = '0;
   bit          m_write  = 1'b0;
   int          m_streak = 0;
   int          m_errs   = 0;
   bit          m_fresh  = 1'b1;

   // Completion log: 1 = dcache, 0 = icache, newest in bit 0.
   logic [63:0] seq  = '0;
   int          seqn = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock cycle: apply inputs, check outputs mid-cycle, advance model.
   task automatic cyc(input bit rst, input bit ir, input logic [31:0] ia,
                      input bit dr, input bit dw, input logic [31:0] da,
                      input logic [31:0] ds, input logic [1:0] rs,
                      input logic [31:0] rl);
      bit dreq;
      bit fin_i;
      bit fin_d;
      bit starve;
      RST = rst; iREN = ir; iaddr = ia; dREN = dr; dWEN = dw;
      daddr = da; dstore = ds; ramstate = rs; ramload = rl;
      #3;
      dreq  = dr | dw;
      fin_i = !rst && serving == 1 && ir && rs == ACCESS;
      fin_d = !rst && serving == 2 && dreq && rs == ACCESS;
      check("iwait", iwait, !fin_i);
      check("dwait", dwait, !fin_d);
      check("ramREN", ramREN, serving != 0 && !m_write);
      check("ramWEN", ramWEN, serving != 0 && m_write);
      if (serving != 0) begin
         check("ramaddr", ramaddr, m_addr);
         if (m_write) check("ramstore", ramstore, m_store);
      end
      if (m_fresh) begin
         check("ramaddr_rst", ramaddr, 0);
         check("ramstore_rst", ramstore, 0);
      end
      check("err_cnt", err_cnt, m_errs);
      if (fin_i) check("iload", iload, rl);
      if (fin_d) check("dload", dload, rl);
      if (!iwait) begin seq = {seq[62:0], 1'b0}; seqn++; end
      if (!dwait) begin seq = {seq[62:0], 1'b1}; seqn++; end

      if (rst) begin
         serving = 0; m_streak = 0; m_errs = 0; m_fresh = 1'b1;
         m_addr = '0; m_store = '0; m_write = 1'b0;
      end else begin
         if (serving != 0 && rs == ERROR && m_errs < (1 << EW) - 1) m_errs++;
         case (serving)
            0: begin
               starve = ir && m_streak == SMAX;
               if (!ir) m_streak = 0;
               if (dreq && !starve) begin
                  serving = 2; m_addr = da; m_store = ds; m_write = dw; m_fresh = 1'b0;
               end else if (ir) begin
                  serving = 1; m_addr = ia; m_write = 1'b0; m_fresh = 1'b0;
               end
            end
            1: begin
               if (!ir) serving = 0;
               else if (rs == ACCESS) begin serving = 0; m_streak = 0; end
            end
            default: begin
               if (!dreq) serving = 0;
               else if (rs == ACCESS) begin
                  serving = 0;
                  if (ir && m_streak < SMAX) m_streak++;
               end
            end
         endcase
      end
      @(posedge CLK);
      #1;
   endtask

   bit          r_ir;
   bit          r_dr;
   bit          r_dw;
   logic [31:0] r_da;
   logic [31:0] r_ia;

   initial begin
      RST = 1'b1; iREN = 1'b0; iaddr = '0; dREN = 1'b0; dWEN = 1'b0;
      daddr = '0; dstore = '0; ramstate = FREE; ramload = '0;
      @(posedge CLK);
      #1;
      cyc(1, 0, 0, 0, 0, 0, 0, FREE, 0);

      // Reset while a dcache write is in service.
      cyc(0, 0, 0, 0, 1, 32'h80, 32'hAA, FREE, 0);
      cyc(0, 0, 0, 0, 1, 32'h80, 32'hAA, BUSY, 0);
      cyc(1, 0, 0, 0, 1, 32'h80, 32'hAA, BUSY, 0);
      cyc(1, 0, 0, 0, 1, 32'h80, 32'hAA, BUSY, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, FREE, 0);

      // Single icache read completing on the third serve cycle.
      cyc(0, 1, 32'h100, 0, 0, 0, 0, FREE, 0);
      cyc(0, 1, 32'h100, 0, 0, 0, 0, BUSY, 32'h1111);
      cyc(0, 1, 32'h100, 0, 0, 0, 0, BUSY, 32'h2222);
      cyc(0, 1, 32'h100, 0, 0, 0, 0, ACCESS, 32'hDEADBEEF);
      cyc(0, 0, 0, 0, 0, 0, 0, FREE, 0);

      // Simultaneous requests: dcache first, icache next.
      for (int unsigned k = 0; k < 4; k++)
         cyc(0, 1, 32'h104, (k < 2), 0, 32'h200, 0, ACCESS, 32'h5000 + k);
      cyc(0, 0, 0, 0, 0, 0, 0, FREE, 0);

      // Starvation bound: four dcache completions, one icache, dcache again.
      cyc(1, 0, 0, 0, 0, 0, 0, FREE, 0);
      seq = '0; seqn = 0;
      for (int unsigned k = 0; k < 14; k++)
         cyc(0, 1, 32'h300, 1, 0, 32'h400 + k, 0, ACCESS, 32'hC000 + k);
      check("starve_count", seqn, 7);
      check("starve_order", seq[6:0], 7'b1111011);
      cyc(0, 0, 0, 0, 0, 0, 0, FREE, 0);

      // Write with two ERROR retries then ACCESS.
      cyc(1, 0, 0, 0, 0, 0, 0, FREE, 0);
      cyc(0, 0, 0, 0, 1, 32'h40, 32'h12345678, FREE, 0);
      cyc(0, 0, 0, 0, 1, 32'h40, 32'h12345678, ERROR, 0);
      cyc(0, 0, 0, 0, 1, 32'h40, 32'h12345678, ERROR, 0);
      cyc(0, 0, 0, 0, 1, 32'h40, 32'h12345678, ACCESS, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, FREE, 0);

      // Abandoned dcache read; waiting icache then granted.
      cyc(0, 1, 32'h500, 1, 0, 32'h600, 0, FREE, 0);
      cyc(0, 1, 32'h500, 1, 0, 32'h600, 0, BUSY, 0);
      cyc(0, 1, 32'h500, 0, 0, 32'h600, 0, BUSY, 0);
      cyc(0, 1, 32'h500, 0, 0, 0, 0, FREE, 0);
      cyc(0, 1, 32'h500, 0, 0, 0, 0, ACCESS, 32'h77);
      cyc(0, 0, 0, 0, 0, 0, 0, FREE, 0);

      // Random traffic with sticky requests, rare resets and frequent errors.
      r_ir = 1'b0; r_dr = 1'b0; r_dw = 1'b0; r_da = '0; r_ia = '0;
      for (int unsigned n = 0; n < 4000; n++) begin
         if ($urandom_range(7) == 0) r_ir = !r_ir;
         if ($urandom_range(7) == 0) r_dr = !r_dr;
         if ($urandom_range(9) == 0) r_dw = !r_dw;
         if ($urandom_range(3) == 0) r_ia = $urandom;
         if ($urandom_range(3) == 0) r_da = $urandom;
         cyc(($urandom_range(1499) == 0), r_ir, r_ia, r_dr, r_dw, r_da,
             $urandom, 2'($urandom_range(3)), $urandom);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
